// File: rtl/astro_mem_pkg.sv
// astro_mem_pkg: shared widths, frame-set geometry and FSM/owner types for the frame memory responder
package astro_mem_pkg;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] FLAG_ADDR = 21'h1F_FFFF;
  // one set = 1 header + 64 template + 1600 window words
  localparam int SET_WORDS = 1665;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;
  typedef enum logic {OWN_PCI, OWN_FPGA} owner_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: PCI-priority grant with a run limit that guarantees the FPGA a slot
//   clk, rst_n    clock, async active-low reset
//   en_i          a grant may be issued this cycle
//   pci_pend_i    host has a request waiting
//   fpga_pend_i   user_interface has a request waiting
//   gnt_o         a grant is issued this cycle
//   own_o         which side the grant goes to
module mem_port_arbiter
  import astro_mem_pkg::*;
#(
  parameter int RUN_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   pci_pend_i,
  input  logic   fpga_pend_i,
  output logic   gnt_o,
  output owner_e own_o
);
  localparam int CW = $clog2(RUN_MAX + 1);
  localparam logic [CW-1:0] RUN_LIM = CW'(RUN_MAX);
  logic [CW-1:0] run_q, run_d;
  logic fpga_turn;
  always_comb begin
    fpga_turn = fpga_pend_i && run_q == RUN_LIM;
    own_o = pci_pend_i && !fpga_turn ? OWN_PCI : OWN_FPGA;
    gnt_o = en_i && (pci_pend_i || fpga_pend_i);
    // only PCI grants made while the FPGA is kept waiting count towards the limit
    run_d = !fpga_pend_i || (gnt_o && own_o == OWN_FPGA) ? '0 : gnt_o ? run_q + 1'b1 : run_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run_q <= '0;
    else run_q <= run_d;
endmodule

// File: rtl/frame_mem_responder.sv
// frame_mem_responder: owns the frame SRAM, serves host PCI and user_interface accesses, holds the flag mailbox
//   clk, rst_n                      clock, async active-low reset
//   pci_req_addr/input_data         host word address / write data
//   pci_wr_en, pci_rd_en            host requests, held until pci_ack
//   pci_ack, pci_rd_data/valid      host accept pulse, read data and its valid pulse
//   host_irq                        mailbox holds an unread nonzero status
//   rd_req, FPGA_wr_en              user_interface requests, held until rd_ready / wr_done
//   req_addr, write_data            user_interface word address / write data
//   rd_data, rd_ready, wr_done      user_interface read data, read pulse, write pulse
//   in_flag                         one-cycle start word written by the host
//   out_flag, flag_we               status word from user_interface and its latch strobe
//   mem_addr/we/wdata/rdata         single-port SRAM macro interface
//   addr_err                        sticky out-of-range access indicator
module frame_mem_responder #(
  parameter int          MEM_AW      = 18,
  parameter int          MEM_LATENCY = 1,
  parameter int          PCI_RUN_MAX = 4,
  parameter logic [20:0] FLAG_ADDR   = 21'h1F_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [20:0]       pci_req_addr,
  input  logic [31:0]       pci_input_data,
  input  logic              pci_wr_en,
  input  logic              pci_rd_en,
  output logic              pci_ack,
  output logic [31:0]       pci_rd_data,
  output logic              pci_rd_valid,
  output logic              host_irq,
  input  logic              rd_req,
  input  logic              FPGA_wr_en,
  input  logic [20:0]       req_addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       rd_data,
  output logic              rd_ready,
  output logic              wr_done,
  output logic [31:0]       in_flag,
  input  logic [31:0]       out_flag,
  input  logic              flag_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              addr_err
);
  import astro_mem_pkg::*;
  state_e state_q;
  owner_e own_q, gnt_own;
  logic gnt, arb_en, pci_pend, fpga_pend;
  logic [ADDR_W-1:0] g_addr;
  logic g_wr, g_flag, g_oor, wr_go, mem_wr, flag_rd, rd_issue, rd_hit, pci_fin, fpga_fin;
  logic [MEM_LATENCY-1:0] vld_q;
  logic zero_q, pci_ack_q, pci_rd_valid_q, rd_ready_q, wr_done_q, host_irq_q, addr_err_q;
  logic [DATA_W-1:0] buf_q, rd_data_q, pci_rd_data_q, in_flag_q, mbox_q;
  mem_port_arbiter #(.RUN_MAX(PCI_RUN_MAX)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (arb_en),
    .pci_pend_i (pci_pend),
    .fpga_pend_i(fpga_pend),
    .gnt_o      (gnt),
    .own_o      (gnt_own)
  );
  always_comb begin
    pci_pend = pci_wr_en | pci_rd_en;
    fpga_pend = FPGA_wr_en | rd_req;
    // the requester still holds its request during its completion pulse, so no grant then
    arb_en = state_q == IDLE && !(pci_ack_q || rd_ready_q || wr_done_q);
    g_addr = gnt_own == OWN_PCI ? pci_req_addr : req_addr;
    g_wr = gnt_own == OWN_PCI ? pci_wr_en : FPGA_wr_en;
    g_flag = gnt_own == OWN_PCI && pci_req_addr == FLAG_ADDR;
    g_oor = g_addr[ADDR_W-1:MEM_AW] != '0 && !g_flag;
    wr_go = gnt && g_wr;
    mem_wr = wr_go && !g_oor && !g_flag;
    flag_rd = gnt && !g_wr && g_flag;
    // out-of-range reads still walk the FSM so both requesters see one read latency
    rd_issue = gnt && !g_wr && !g_flag;
    rd_hit = state_q == RD_WAIT && vld_q[MEM_LATENCY-1];
    pci_fin = state_q == RESP && own_q == OWN_PCI;
    fpga_fin = state_q == RESP && own_q == OWN_FPGA;
    mem_addr = gnt ? g_addr[MEM_AW-1:0] : '0;
    mem_we = mem_wr;
    mem_wdata = !mem_wr ? '0 : gnt_own == OWN_PCI ? pci_input_data : write_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      own_q <= OWN_PCI;
      zero_q <= 1'b0;
      vld_q <= '0;
      buf_q <= '0;
      pci_ack_q <= 1'b0;
      pci_rd_valid_q <= 1'b0;
      pci_rd_data_q <= '0;
      rd_ready_q <= 1'b0;
      rd_data_q <= '0;
      wr_done_q <= 1'b0;
      in_flag_q <= '0;
      mbox_q <= '0;
      host_irq_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q <= rd_issue ? RD_WAIT : rd_hit ? RESP : state_q == RESP ? IDLE : state_q;
      if (rd_issue) begin
        own_q <= gnt_own;
        zero_q <= g_oor;
      end
      vld_q <= (vld_q << 1) | MEM_LATENCY'(rd_issue);
      if (rd_hit) buf_q <= zero_q ? '0 : mem_rdata;
      pci_ack_q <= (wr_go && gnt_own == OWN_PCI) || flag_rd || pci_fin;
      pci_rd_valid_q <= flag_rd || pci_fin;
      if (flag_rd) pci_rd_data_q <= mbox_q;
      else if (pci_fin) pci_rd_data_q <= buf_q;
      rd_ready_q <= fpga_fin;
      if (fpga_fin) rd_data_q <= buf_q;
      wr_done_q <= wr_go && gnt_own == OWN_FPGA;
      in_flag_q <= wr_go && g_flag ? pci_input_data : '0;
      if (flag_we) mbox_q <= out_flag;
      // a status update racing a host read wins: the new word stays pending
      host_irq_q <= flag_we ? |out_flag : host_irq_q && !flag_rd;
      addr_err_q <= addr_err_q || (gnt && g_oor);
    end
  assign pci_ack = pci_ack_q;
  assign pci_rd_valid = pci_rd_valid_q;
  assign pci_rd_data = pci_rd_data_q;
  assign rd_ready = rd_ready_q;
  assign rd_data = rd_data_q;
  assign wr_done = wr_done_q;
  assign in_flag = in_flag_q;
  assign host_irq = host_irq_q;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_frame_mem_responder.sv
// tb_frame_mem_responder: randomized self-checking bench against a word-array reference of the frame memory
module tb_frame_mem_responder;
  import astro_mem_pkg::*;
  localparam int AW = 18;
  localparam int LAT = 1;
  localparam int RUN = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [20:0] pci_req_addr = '0;
  logic [31:0] pci_input_data = '0;
  logic pci_wr_en = 1'b0;
  logic pci_rd_en = 1'b0;
  logic pci_ack, pci_rd_valid, host_irq, rd_ready, wr_done, mem_we, addr_err;
  logic [31:0] pci_rd_data, rd_data, in_flag, mem_wdata, mem_rdata;
  logic rd_req = 1'b0;
  logic FPGA_wr_en = 1'b0;
  logic [20:0] req_addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] out_flag = '0;
  logic flag_we = 1'b0;
  logic [AW-1:0] mem_addr;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] sram [0:(1<<AW)-1];
  logic [31:0] pipe [LAT];

  frame_mem_responder #(.MEM_AW(AW), .MEM_LATENCY(LAT), .PCI_RUN_MAX(RUN), .FLAG_ADDR(FLAG_ADDR)) dut (
    .clk(clk), .rst_n(rst_n),
    .pci_req_addr(pci_req_addr), .pci_input_data(pci_input_data),
    .pci_wr_en(pci_wr_en), .pci_rd_en(pci_rd_en), .pci_ack(pci_ack),
    .pci_rd_data(pci_rd_data), .pci_rd_valid(pci_rd_valid), .host_irq(host_irq),
    .rd_req(rd_req), .FPGA_wr_en(FPGA_wr_en), .req_addr(req_addr), .write_data(write_data),
    .rd_data(rd_data), .rd_ready(rd_ready), .wr_done(wr_done),
    .in_flag(in_flag), .out_flag(out_flag), .flag_we(flag_we),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // SRAM macro: registered read with LAT cycles of latency
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    pipe[0] <= sram[mem_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  function automatic logic [31:0] model_rd(input logic [20:0] a);
    if (a[20:AW] != 0) return 32'h0;
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  function automatic void model_wr(input logic [20:0] a, input logic [31:0] d);
    if (a[20:AW] == 0) ref_mem[int'(a)] = d;
  endfunction

  task automatic pci_wr(input logic [20:0] a, input logic [31:0] d, output int n);
    @(posedge clk); #1;
    pci_req_addr = a; pci_input_data = d; pci_wr_en = 1'b1; n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (pci_ack) n = i;
    end
    pci_wr_en = 1'b0;
  endtask

  task automatic pci_rd(input logic [20:0] a, output logic [31:0] d, output logic v, output int n);
    @(posedge clk); #1;
    pci_req_addr = a; pci_rd_en = 1'b1; n = 0; d = 'x; v = 1'b0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (pci_ack) begin n = i; d = pci_rd_data; v = pci_rd_valid; end
    end
    pci_rd_en = 1'b0;
  endtask

  task automatic fpga_wr(input logic [20:0] a, input logic [31:0] d, output int n);
    @(posedge clk); #1;
    req_addr = a; write_data = d; FPGA_wr_en = 1'b1; n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (wr_done) n = i;
    end
    FPGA_wr_en = 1'b0;
  endtask

  task automatic fpga_rd(input logic [20:0] a, output logic [31:0] d, output int n);
    @(posedge clk); #1;
    req_addr = a; rd_req = 1'b1; n = 0; d = 'x;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (rd_ready) begin n = i; d = rd_data; end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({pci_ack, pci_rd_valid, host_irq, rd_ready, wr_done, mem_we, addr_err} !== 7'b0) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 0", {pci_ack, pci_rd_valid, host_irq, rd_ready, wr_done, mem_we, addr_err});
    end
    vectors++;
    if ({rd_data, pci_rd_data, in_flag, mem_wdata} !== 128'h0) begin
      miscompares++; $display("FAIL reset_data got %h %h %h %h exp 0", rd_data, pci_rd_data, in_flag, mem_wdata);
    end
    vectors++;
    if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_set_load();
    int n, bad = 0;
    logic [31:0] d;
    for (int i = 0; i < SET_WORDS; i++) begin
      d = i == 0 ? 32'h42 : 32'h4143_4143;
      pci_wr(21'(i), d, n);
      if (n != 1) bad++;
      model_wr(21'(i), d);
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL set_load_acks got %0d late acks exp 0", bad); end
    foreach (ref_mem[a]) if (a == 0 || a == 1 || a == SET_WORDS - 1) begin
      fpga_rd(21'(a), d, n);
      vectors++;
      if (d !== model_rd(21'(a))) begin miscompares++; $display("FAIL set_rd[%0d] got %h exp %h", a, d, model_rd(21'(a))); end
      vectors++;
      if (n != LAT + 2) begin miscompares++; $display("FAIL set_rd_lat[%0d] got %0d exp %0d", a, n, LAT + 2); end
    end
  endtask

  task automatic test_flag_write();
    int pulses = 0, acks = 0;
    logic [31:0] seen = '0;
    logic we_seen;
    @(posedge clk); #1;
    pci_req_addr = FLAG_ADDR; pci_input_data = 32'h0001_0000; pci_wr_en = 1'b1;
    #1 we_seen = mem_we;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      we_seen |= mem_we;
      if (in_flag != 0) begin pulses++; seen = in_flag; end
      if (pci_ack) begin acks++; pci_wr_en = 1'b0; end
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL flag_pulse_len got %0d exp 1", pulses); end
    vectors++;
    if (seen !== 32'h0001_0000) begin miscompares++; $display("FAIL flag_value got %h exp 00010000", seen); end
    vectors++;
    if (acks != 1) begin miscompares++; $display("FAIL flag_ack got %0d exp 1", acks); end
    vectors++;
    if (we_seen !== 1'b0) begin miscompares++; $display("FAIL flag_mem_we got %b exp 0", we_seen); end
  endtask

  task automatic test_mailbox();
    logic [31:0] d;
    logic v;
    int n;
    @(posedge clk); #1;
    out_flag = 32'h4; flag_we = 1'b1;
    @(posedge clk); #1;
    flag_we = 1'b0;
    vectors++;
    if (host_irq !== 1'b1) begin miscompares++; $display("FAIL irq_set got %b exp 1", host_irq); end
    pci_rd(FLAG_ADDR, d, v, n);
    vectors++;
    if (d !== 32'h4 || v !== 1'b1) begin miscompares++; $display("FAIL mbox_rd got %h/%b exp 00000004/1", d, v); end
    vectors++;
    if (n != 1) begin miscompares++; $display("FAIL mbox_lat got %0d exp 1", n); end
    vectors++;
    if (host_irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got %b exp 0", host_irq); end
    // status update on the same edge as the host read
    @(posedge clk); #1;
    out_flag = 32'h7; flag_we = 1'b1;
    @(posedge clk); #1;
    pci_req_addr = FLAG_ADDR; pci_rd_en = 1'b1; out_flag = 32'h9;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clk); #1;
      flag_we = 1'b0;
      if (pci_ack) begin n = i; d = pci_rd_data; end
    end
    pci_rd_en = 1'b0;
    vectors++;
    if (d !== 32'h7 || n != 1) begin miscompares++; $display("FAIL race_rd got %h after %0d exp 00000007 after 1", d, n); end
    vectors++;
    if (host_irq !== 1'b1) begin miscompares++; $display("FAIL race_irq got %b exp 1", host_irq); end
    pci_rd(FLAG_ADDR, d, v, n);
    vectors++;
    if (d !== 32'h9 || host_irq !== 1'b0) begin miscompares++; $display("FAIL race_new got %h irq %b exp 00000009 irq 0", d, host_irq); end
  endtask

  task automatic test_back_to_back();
    int n = 0, run = 0, max_run = 0;
    logic is_f;
    @(posedge clk); #1;
    pci_req_addr = 21'(32'h100 + $urandom_range(0, 255)); pci_input_data = $urandom; pci_wr_en = 1'b1;
    req_addr = 21'(32'h200 + $urandom_range(0, 255)); write_data = $urandom; FPGA_wr_en = 1'b1;
    for (int c = 0; c < 400 && n < 20; c++) begin
      @(posedge clk); #1;
      if (pci_ack || wr_done) begin
        is_f = wr_done;
        vectors++;
        if (is_f !== (n % 5 == 4)) begin miscompares++; $display("FAIL arb_grant[%0d] got fpga=%b exp fpga=%b", n, is_f, n % 5 == 4); end
        if (is_f) begin
          model_wr(req_addr, write_data);
          req_addr = 21'(32'h200 + $urandom_range(0, 255)); write_data = $urandom; run = 0;
        end else begin
          model_wr(pci_req_addr, pci_input_data);
          pci_req_addr = 21'(32'h100 + $urandom_range(0, 255)); pci_input_data = $urandom;
          run++; if (run > max_run) max_run = run;
        end
        n++;
      end
    end
    pci_wr_en = 1'b0; FPGA_wr_en = 1'b0;
    vectors++;
    if (n != 20) begin miscompares++; $display("FAIL arb_count got %0d exp 20", n); end
    vectors++;
    if (max_run > RUN) begin miscompares++; $display("FAIL arb_starve got %0d exp <=%0d", max_run, RUN); end
  endtask

  task automatic test_range();
    logic [31:0] d;
    logic v;
    int n;
    vectors++;
    if (addr_err !== 1'b0) begin miscompares++; $display("FAIL err_clean got %b exp 0", addr_err); end
    fpga_rd(21'h04_0000, d, n);
    vectors++;
    if (d !== 32'h0 || n != LAT + 2) begin miscompares++; $display("FAIL oor_rd got %h after %0d exp 0 after %0d", d, n, LAT + 2); end
    vectors++;
    if (addr_err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b exp 1", addr_err); end
    fpga_wr(21'h04_0000, 32'hDEAD_BEEF, n);
    vectors++;
    if (n != 1) begin miscompares++; $display("FAIL oor_wr_done got %0d exp 1", n); end
    fpga_rd(21'h0, d, n);
    vectors++;
    if (d !== model_rd(21'h0)) begin miscompares++; $display("FAIL oor_alias got %h exp %h", d, model_rd(21'h0)); end
    fpga_rd(FLAG_ADDR, d, n);
    vectors++;
    if (d !== 32'h0 || n != LAT + 2) begin miscompares++; $display("FAIL fpga_flag got %h after %0d exp 0", d, n); end
    pci_rd(21'h10_0000, d, v, n);
    vectors++;
    if (d !== 32'h0 || v !== 1'b1 || n != LAT + 2) begin miscompares++; $display("FAIL pci_oor got %h/%b after %0d exp 0/1", d, v, n); end
  endtask

  task automatic test_random();
    logic [20:0] a;
    logic [31:0] d, got;
    logic v;
    int n;
    for (int k = 0; k < 80; k++) begin
      a = $urandom_range(0, 15) == 0 ? 21'(32'h4_0000 + $urandom_range(0, 255)) : 21'($urandom_range(0, SET_WORDS - 1));
      d = $urandom;
      case ($urandom_range(0, 3))
        0: begin pci_wr(a, d, n); model_wr(a, d); vectors++;
             if (n != 1) begin miscompares++; $display("FAIL rnd_pci_wr[%0d] got %0d exp 1", k, n); end end
        1: begin fpga_wr(a, d, n); model_wr(a, d); vectors++;
             if (n != 1) begin miscompares++; $display("FAIL rnd_fpga_wr[%0d] got %0d exp 1", k, n); end end
        2: begin pci_rd(a, got, v, n); vectors++;
             if (got !== model_rd(a) || v !== 1'b1 || n != LAT + 2) begin
               miscompares++; $display("FAIL rnd_pci_rd[%0d] a=%h got %h/%b/%0d exp %h/1/%0d", k, a, got, v, n, model_rd(a), LAT + 2);
             end end
        default: begin fpga_rd(a, got, n); vectors++;
             if (got !== model_rd(a) || n != LAT + 2) begin
               miscompares++; $display("FAIL rnd_fpga_rd[%0d] a=%h got %h/%0d exp %h/%0d", k, a, got, n, model_rd(a), LAT + 2);
             end end
      endcase
    end
  endtask

  task automatic test_reset_midread();
    logic seen = 1'b0;
    logic [31:0] d;
    int n;
    @(posedge clk); #1;
    req_addr = 21'h1; rd_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; rd_req = 1'b0;
    #1;
    vectors++;
    if ({rd_ready, pci_ack, addr_err, host_irq} !== 4'b0 || rd_data !== 32'h0) begin
      miscompares++; $display("FAIL midrd_outputs got %b data %h exp 0", {rd_ready, pci_ack, addr_err, host_irq}, rd_data);
    end
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; seen |= rd_ready; end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; seen |= rd_ready; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL midrd_ghost got rd_ready=%b exp 0", seen); end
    fpga_rd(21'h1, d, n);
    vectors++;
    if (d !== model_rd(21'h1) || n != LAT + 2) begin miscompares++; $display("FAIL midrd_first got %h/%0d exp %h/%0d", d, n, model_rd(21'h1), LAT + 2); end
  endtask

  initial begin
    test_reset();
    test_set_load();
    test_flag_write();
    test_mailbox();
    test_back_to_back();
    test_range();
    test_random();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
